// File: rtl/ms_pkg.sv
// Shared types and constants for the millisecond BCD stopwatch core.
// Holds the control-state enum, the BCD digit type and a packed-BCD increment helper.
package ms_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } ms_state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam int unsigned MS_DIGITS = 4;
  localparam logic [15:0] BCD_MAX   = 16'h9999;

  // Value the packed count takes after one tick; used where the post-update count is needed
  // in the same cycle as the tick.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < MS_DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c           = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ms_bcd_counter_if.sv
// Control/status bundle between the stopwatch core, the prescaler and the display stage.
// LAP / LAP_BCD exist only when LAP_CAPTURE_EN is defined.
interface ms_bcd_counter_if;
  logic [15:0] COUNT;
  logic        START;
  logic        STOP;
  logic        CLEAR;
  logic        PRE_CLR;
  logic [15:0] BCD;
  logic        RUNNING;
  logic        OVF;
`ifdef LAP_CAPTURE_EN
  logic        LAP;
  logic [15:0] LAP_BCD;
`endif

  modport slave (
    input  COUNT,
    input  START,
    input  STOP,
    input  CLEAR,
`ifdef LAP_CAPTURE_EN
    input  LAP,
    output LAP_BCD,
`endif
    output PRE_CLR,
    output BCD,
    output RUNNING,
    output OVF
  );

  modport master (
    output COUNT,
    output START,
    output STOP,
    output CLEAR,
`ifdef LAP_CAPTURE_EN
    output LAP,
    input  LAP_BCD,
`endif
    input  PRE_CLR,
    input  BCD,
    input  RUNNING,
    input  OVF
  );

endinterface

// File: rtl/bcd_digit.sv
// One decade (0..9) counter stage; advances when en and carry_in are both high.
// clr has priority over counting.
module bcd_digit
  import ms_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       clr,
  input  logic       en,
  input  logic       carry_in,
  output bcd_digit_t digit,
  output logic       carry_out
);

  bcd_digit_t digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = '0;
    end else if (en && carry_in) begin
      digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit     = digit_q;
  assign carry_out = carry_in && (digit_q == 4'd9);

endmodule

// File: rtl/ms_bcd_counter.sv
// Millisecond stopwatch: start/stop/clear FSM, prescaler clear, 4-digit BCD count, sticky OVF.
// Optional lap register enabled by defining LAP_CAPTURE_EN.
module ms_bcd_counter
  import ms_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000
) (
  input logic              CLK,
  input logic              RST,
  ms_bcd_counter_if.slave  bus
);

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  ms_state_e state_q, state_d;
  logic      tick;
  logic      ovf_q, ovf_d;
  logic [15:0]          bcd;
  logic [MS_DIGITS:0]   carry;

  assign tick = (state_q == RUN) && (bus.COUNT == TICK_LAST);

  // Prescaler is held at zero outside RUN so every resume begins a full period.
  assign bus.PRE_CLR = tick || (state_q != RUN) || bus.CLEAR;

  always_comb begin
    state_d = state_q;
    if (bus.CLEAR) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (bus.START && !bus.STOP) state_d = RUN;
        RUN:     if (bus.STOP) state_d = PAUSE;
        PAUSE:   if (bus.START && !bus.STOP) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < MS_DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .CLK       (CLK),
      .RST       (RST),
      .clr       (bus.CLEAR),
      .en        (tick),
      .carry_in  (carry[i]),
      .digit     (bcd[4*i +: 4]),
      .carry_out (carry[i+1])
    );
  end

  // Carry out of the top digit on a tick means 9999 is wrapping to 0000.
  always_comb begin
    ovf_d = ovf_q;
    if (bus.CLEAR) begin
      ovf_d = 1'b0;
    end else if (tick && carry[MS_DIGITS]) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.BCD     = bcd;
  assign bus.RUNNING = (state_q == RUN);
  assign bus.OVF     = ovf_q;

`ifdef LAP_CAPTURE_EN
  logic [15:0] lap_q, lap_d;

  always_comb begin
    lap_d = lap_q;
    if (bus.CLEAR) begin
      lap_d = '0;
    end else if (bus.LAP && (state_q == RUN)) begin
      lap_d = tick ? bcd_inc(bcd) : bcd;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      lap_q <= '0;
    end else begin
      lap_q <= lap_d;
    end
  end

  assign bus.LAP_BCD = lap_q;
`endif

endmodule

// File: tb/tb_ms_bcd_counter.sv
// Directed bench for ms_bcd_counter with TICK_DIV = 10 and a 16-bit prescaler model in the loop.
// Expected outputs are queued when stimulus is applied and popped when the DUT is sampled.
module tb_ms_bcd_counter;

  localparam int unsigned TD = 10;

  logic CLK = 1'b0;
  logic RST;
  logic fast;
  logic [15:0] pre_q;
  logic digit_bad = 1'b0;

  ms_bcd_counter_if bus ();

  ms_bcd_counter #(.TICK_DIV(TD)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Prescaler model; "fast" pins COUNT at the terminal value so every RUN cycle is a tick.
  always_ff @(posedge CLK) begin
    if (bus.PRE_CLR) pre_q <= '0;
    else             pre_q <= pre_q + 16'd1;
  end
  assign bus.COUNT = fast ? 16'(TD - 1) : pre_q;

  always @(negedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (bus.BCD[4*i +: 4] > 4'd9) digit_bad <= 1'b1;
    end
  end

  typedef struct {
    string       tag;
    logic [15:0] bcd;
    logic        run;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic push_exp(input string tag, input logic [15:0] b, input logic r, input logic o);
    exp_t e;
    e.tag = tag;
    e.bcd = b;
    e.run = r;
    e.ovf = o;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    assert (bus.BCD === e.bcd) else begin
      mismatched++;
      $error("FAIL %s.bcd observed=%h expected=%h", e.tag, bus.BCD, e.bcd);
    end
    compared++;
    assert (bus.RUNNING === e.run) else begin
      mismatched++;
      $error("FAIL %s.running observed=%b expected=%b", e.tag, bus.RUNNING, e.run);
    end
    compared++;
    assert (bus.OVF === e.ovf) else begin
      mismatched++;
      $error("FAIL %s.ovf observed=%b expected=%b", e.tag, bus.OVF, e.ovf);
    end
  endtask

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic pulse(input logic s, input logic p, input logic c);
    bus.START = s;
    bus.STOP  = p;
    bus.CLEAR = c;
    edges(1);
    bus.START = 1'b0;
    bus.STOP  = 1'b0;
    bus.CLEAR = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    RST       = 1'b0;
    fast      = 1'b0;
    bus.START = 1'b0;
    bus.STOP  = 1'b0;
    bus.CLEAR = 1'b0;
`ifdef LAP_CAPTURE_EN
    bus.LAP   = 1'b0;
`endif
    #1;
    push_exp("reset_t0", 16'h0000, 1'b0, 1'b0);
    check_out();
    check_val("reset_t0.pre_clr", 16'(bus.PRE_CLR), 16'd1);
    edges(3);
    RST = 1'b1;
    edges(2);
    push_exp("idle", 16'h0000, 1'b0, 1'b0);
    check_out();

    // Basic count and first-increment latency
    push_exp("start", 16'h0000, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    check_out();
    edges(9);
    check_val("tick_pre_clr", 16'(bus.PRE_CLR), 16'd1);
    push_exp("before_first", 16'h0000, 1'b1, 1'b0);
    check_out();
    edges(1);
    push_exp("first_inc", 16'h0001, 1'b1, 1'b0);
    check_out();
    check_val("post_tick_pre_clr", 16'(bus.PRE_CLR), 16'd0);
    edges(25);
    push_exp("35_cycles", 16'h0003, 1'b1, 1'b0);
    check_out();
    n = 0;
    for (int i = 0; i < 30; i++) begin
      edges(1);
      if (bus.PRE_CLR) n++;
    end
    check_val("pre_clr_pulses", 16'(n), 16'd3);
    edges(5);

    // Pause / resume
    push_exp("stop_at_7", 16'h0007, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    check_out();
    edges(100);
    push_exp("paused_100", 16'h0007, 1'b0, 1'b0);
    check_out();
    check_val("paused_count", bus.COUNT, 16'd0);
    pulse(1'b1, 1'b0, 1'b0);
    edges(9);
    push_exp("resume_9", 16'h0007, 1'b1, 1'b0);
    check_out();
    edges(1);
    push_exp("resume_10", 16'h0008, 1'b1, 1'b0);
    check_out();

    // Collisions
    push_exp("stop_start", 16'h0008, 1'b0, 1'b0);
    pulse(1'b1, 1'b1, 1'b0);
    check_out();
    pulse(1'b1, 1'b0, 1'b0);
    edges(9);
    push_exp("stop_on_tick", 16'h0009, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    check_out();
    edges(20);
    push_exp("stop_tick_hold", 16'h0009, 1'b0, 1'b0);
    check_out();
    pulse(1'b1, 1'b0, 1'b0);
    edges(9);
    push_exp("clear_on_tick", 16'h0000, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    check_out();
    check_val("clear_pre_clr", 16'(bus.PRE_CLR), 16'd1);

    // Asynchronous reset mid-RUN
    pulse(1'b1, 1'b0, 1'b0);
    edges(420);
    push_exp("at_0042", 16'h0042, 1'b1, 1'b0);
    check_out();
    #2;
    RST = 1'b0;
    #1;
    push_exp("async_reset", 16'h0000, 1'b0, 1'b0);
    check_out();
    check_val("async_reset.pre_clr", 16'(bus.PRE_CLR), 16'd1);
    edges(2);
    RST = 1'b1;
    edges(1);

    // Carries and wrap, one tick per cycle
    fast = 1'b1;
    pulse(1'b1, 1'b0, 1'b0);
    edges(99);
    push_exp("at_0099", 16'h0099, 1'b1, 1'b0);
    check_out();
    edges(1);
    push_exp("carry_0100", 16'h0100, 1'b1, 1'b0);
    check_out();
    edges(899);
    push_exp("at_0999", 16'h0999, 1'b1, 1'b0);
    check_out();
    edges(1);
    push_exp("carry_1000", 16'h1000, 1'b1, 1'b0);
    check_out();
    edges(8999);
    push_exp("at_9999", 16'h9999, 1'b1, 1'b0);
    check_out();
    edges(1);
    push_exp("wrap", 16'h0000, 1'b1, 1'b1);
    check_out();
    edges(5);
    push_exp("ovf_sticky", 16'h0005, 1'b1, 1'b1);
    check_out();
    push_exp("clear_ovf", 16'h0000, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    check_out();
    fast = 1'b0;
    check_val("digit_le_9", 16'(digit_bad), 16'd0);
    check_val("sb_drained", 16'(sb.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ms_bcd_counter.md
# ms_bcd_counter

Millisecond stopwatch core sitting directly downstream of the 16-bit free-running prescaler counter. It watches the prescaler value, emits a synchronous clear back to the prescaler every TICK_DIV cycles, and on each such millisecond tick advances a 4-digit packed-BCD count (0000–9999). A start/stop/clear control FSM gates counting, and the BCD output feeds the display stage.

## Interface
- TICK_DIV, 50000, prescaler cycles per millisecond (2..65536; 50000 for a 50 MHz CLK)
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-low reset
- COUNT  in  16  prescaler value Q from the 16-bit counter
- START  in  1  single-cycle pulse: start or resume counting
- STOP  in  1  single-cycle pulse: pause counting
- CLEAR  in  1  single-cycle pulse: zero count, return to idle
- PRE_CLR  out  1  combinational; drives the prescaler's synchronous RST
- BCD  out  16  packed BCD ms count, digit 3 = [15:12] … digit 0 = [3:0]
- RUNNING  out  1  high while in RUN
- OVF  out  1  sticky wrap flag

## Operation
- FSM states: IDLE (BCD = 0), RUN, PAUSE.
- IDLE: START → RUN. STOP ignored. CLEAR → IDLE.
- RUN: CLEAR → IDLE (BCD ← 0, OVF ← 0). STOP → PAUSE. START ignored.
- PAUSE: CLEAR → IDLE. START → RUN (resume, BCD kept). STOP ignored.
- Pulse priority in the same cycle: CLEAR > STOP > START.
- tick = (state == RUN) && (COUNT == TICK_DIV-1).
- PRE_CLR = tick || (state != RUN) || CLEAR. The prescaler is held at 0 whenever not running, so every resume starts a full millisecond.
- On tick: digit 0 increments. A digit at 9 wraps to 0 and carries into the next digit. 9999 → 0000 and sets OVF. Digits never hold values > 9.
- Tick coincident with STOP: the increment happens and the state goes to PAUSE.
- Tick coincident with CLEAR: CLEAR wins, BCD = 0000.
- OVF is cleared only by CLEAR or reset.
- Reset (async, any time): state IDLE, BCD 0000, RUNNING 0, OVF 0. PRE_CLR is therefore 1 while RST is low.

## Timing
- All state, BCD and OVF updates are registered on the CLK rising edge.
- PRE_CLR is combinational from state, COUNT and CLEAR. No other combinational paths to outputs.
- START sampled at edge k → RUNNING = 1 after edge k. The prescaler leaves 0 at edge k+1. The first BCD increment is visible after edge k+TICK_DIV.
- Steady state: one increment per TICK_DIV cycles, with PRE_CLR high for exactly one cycle per period.
- STOP at edge k → BCD frozen from edge k on. Resume latency to the next increment is again exactly TICK_DIV cycles.

## Configuration
- LAP_CAPTURE_EN defined: adds input LAP (pulse) and output LAP_BCD [15:0], reset 0.
  - LAP in RUN: LAP_BCD ← BCD value after that edge's update. Counting is unaffected.
  - LAP is ignored in IDLE and PAUSE.
  - CLEAR zeroes LAP_BCD.
- LAP_CAPTURE_EN not defined: LAP and LAP_BCD ports and logic are absent. All other behaviour is identical.

## Structure
- Shared package ms_pkg holds:
  - state enum (IDLE, RUN, PAUSE)
  - 4-bit BCD digit type
  - constant MS_DIGITS = 4
  - constant BCD_MAX = 16'h9999
- Sub-module bcd_digit: one decade counter with inputs en and carry_in, outputs digit and carry_out (carry_out = carry_in && digit == 9). Instantiated 4×, chained through carry.
- Top level holds the FSM, tick/PRE_CLR logic, OVF, and the optional lap register.

## Test plan
Benches use TICK_DIV = 10 with a model of the 16-bit prescaler in the loop.
- Reset: assert RST low mid-RUN at BCD 0042 → BCD 0000, RUNNING 0, OVF 0, PRE_CLR 1 immediately, without waiting for a clock edge.
- Basic count: START, then 35 cycles → BCD 0003. PRE_CLR pulses every 10 cycles. First increment exactly 10 cycles after the START edge.
- Pause/resume: STOP at BCD 0007, idle 100 cycles → BCD stays 0007 and COUNT stays 0. START → 0008 exactly 10 cycles later.
- Carries: run from 0099 → 0100, and from 0999 → 1000 on a single tick. No digit ever exceeds 9.
- Wrap: from 9999, one tick → 0000 and OVF = 1. OVF stays 1 through further ticks until CLEAR, then 0.
- Collisions:
  - STOP+START in one cycle → PAUSE.
  - CLEAR on a tick cycle → BCD 0000, IDLE.
  - STOP on a tick cycle → increment kept, then PAUSE.
